// File: rtl/bernoulli_random_feeder.sv
// Repacks IN_WIDTH-bit XOF words into COMP_WIDTH-bit slices for a Bernoulli comparator.
// Optional: define BERNOULLI_FEEDER_CNT_EN to add the 32-bit sample_count output.
module bernoulli_random_feeder #(
    parameter int COMP_WIDTH = 8,
    parameter int IN_WIDTH   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  flush,
    input  logic [COMP_WIDTH-1:0] thr_in,
    input  logic                  thr_load,
    output logic [COMP_WIDTH-1:0] random_value,
    output logic [COMP_WIDTH-1:0] threshold,
    output logic                  out_valid,
    input  logic                  out_ready
`ifdef BERNOULLI_FEEDER_CNT_EN
    ,
    output logic [31:0]           sample_count
`endif
);

    localparam int BUF_W = 2 * IN_WIDTH;
    localparam int CNT_W = $clog2(BUF_W + 1);

    localparam logic [CNT_W-1:0]      BUF_W_C    = CNT_W'(BUF_W);
    localparam logic [CNT_W-1:0]      IN_W_C     = CNT_W'(IN_WIDTH);
    localparam logic [CNT_W-1:0]      COMP_W_C   = CNT_W'(COMP_WIDTH);
    localparam logic [COMP_WIDTH-1:0] THR_RESET  = {1'b1, {(COMP_WIDTH-1){1'b0}}};

    logic [BUF_W-1:0] buffer_q;
    logic [BUF_W-1:0] buffer_d;
    logic [BUF_W-1:0] shifted;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [CNT_W-1:0] cnt_base;
    logic             push;
    logic             pop;

    // Written as a subtraction on the right so the compare never overflows CNT_W.
    assign in_ready     = (bit_cnt_q <= BUF_W_C - IN_W_C) && !flush;
    assign out_valid    = (bit_cnt_q >= COMP_W_C) && !flush;
    assign random_value = buffer_q[COMP_WIDTH-1:0];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        shifted   = buffer_q;
        cnt_base  = bit_cnt_q;
        if (pop) begin
            shifted  = buffer_q >> COMP_WIDTH;
            cnt_base = bit_cnt_q - COMP_W_C;
        end

        buffer_d  = shifted;
        bit_cnt_d = cnt_base;
        // Bits above the fill level are always zero, so the new word can be OR-ed in.
        if (push) begin
            buffer_d  = shifted | (BUF_W'(in_data) << cnt_base);
            bit_cnt_d = cnt_base + IN_W_C;
        end

        if (flush) begin
            buffer_d  = '0;
            bit_cnt_d = '0;
        end
    end

    // NOTE: the buffer is plain flops rather than a RAM, so resetting it costs nothing special.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            buffer_q  <= '0;
            bit_cnt_q <= '0;
        end else begin
            buffer_q  <= buffer_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Threshold is independent of the data path and of flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            threshold <= THR_RESET;
        end else if (thr_load) begin
            threshold <= thr_in;
        end
    end

`ifdef BERNOULLI_FEEDER_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
        end else if (flush) begin
            sample_count <= '0;
        end else if (pop) begin
            sample_count <= sample_count + 32'd1;
        end
    end
`endif

endmodule
